// File: rtl/bsg_fifo_small_pkg.sv
// Shared types and sizing helpers for the small 1r1w FIFO family.
package bsg_fifo_small_pkg;

  // Enqueue handshake: valid&ready, or valid alone (producer already checked ready).
  typedef enum logic {
    HS_READY_AND_VALID  = 1'b0,
    HS_READY_THEN_VALID = 1'b1
  } hs_mode_e;

  // Pointer width; at least one bit even for the two-entry case.
  function automatic int unsigned ptr_width(input int unsigned els);
    return (els <= 2) ? 1 : $clog2(els);
  endfunction

  // Occupancy counter width, able to hold the value els.
  function automatic int unsigned count_width(input int unsigned els);
    return $clog2(els + 1);
  endfunction

endpackage

// File: rtl/bsg_fifo_small_tracker.sv
// Read/write pointers, occupancy count and status flags for the small FIFO.
module bsg_fifo_small_tracker
  import bsg_fifo_small_pkg::*;
#(
  parameter int unsigned els_p          = 4,
  parameter int unsigned afull_slack_p  = 1,
  parameter int unsigned aempty_slack_p = 1,
  localparam int unsigned ptr_w_lp      = ptr_width(els_p),
  localparam int unsigned cnt_w_lp      = count_width(els_p)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                clear_i,
  input  logic                enq_i,
  input  logic                deq_i,
  output logic [ptr_w_lp-1:0] rptr_o,
  output logic [ptr_w_lp-1:0] wptr_o,
  output logic [cnt_w_lp-1:0] count_o,
  output logic                full_o,
  output logic                empty_o,
  output logic                almost_full_o,
  output logic                almost_empty_o
);

  logic [ptr_w_lp-1:0] rptr_r, rptr_n;
  logic [ptr_w_lp-1:0] wptr_r, wptr_n;
  logic [cnt_w_lp-1:0] count_r, count_n;
  logic [cnt_w_lp-1:0] free_c;

  // Next pointers and count; explicit wrap compare keeps non-pow2 depths safe.
  always_comb begin
    rptr_n  = rptr_r;
    wptr_n  = wptr_r;
    count_n = count_r;
    if (clear_i) begin
      rptr_n  = '0;
      wptr_n  = '0;
      count_n = '0;
    end else begin
      if (enq_i)
        wptr_n = (wptr_r == ptr_w_lp'(els_p - 1)) ? '0 : wptr_r + ptr_w_lp'(1);
      if (deq_i)
        rptr_n = (rptr_r == ptr_w_lp'(els_p - 1)) ? '0 : rptr_r + ptr_w_lp'(1);
      case ({enq_i, deq_i})
        2'b10:   count_n = count_r + cnt_w_lp'(1);
        2'b01:   count_n = count_r - cnt_w_lp'(1);
        default: count_n = count_r;
      endcase
    end
  end

  // State registers; reset empties the FIFO immediately.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rptr_r  <= '0;
      wptr_r  <= '0;
      count_r <= '0;
    end else begin
      rptr_r  <= rptr_n;
      wptr_r  <= wptr_n;
      count_r <= count_n;
    end
  end

  // Status decoded from the registered count only, so flags are glitch-free per cycle.
  assign free_c         = cnt_w_lp'(els_p) - count_r;
  assign full_o         = (count_r == cnt_w_lp'(els_p));
  assign empty_o        = (count_r == '0);
  assign almost_full_o  = (free_c <= cnt_w_lp'(afull_slack_p));
  assign almost_empty_o = (count_r <= cnt_w_lp'(aempty_slack_p));
  assign rptr_o         = rptr_r;
  assign wptr_o         = wptr_r;
  assign count_o        = count_r;

endmodule

// File: rtl/bsg_fifo_1r1w_small_count.sv
// Small flop-based 1r1w FIFO with occupancy count and almost-full/empty flags.
// Optional synchronous flush port clear_i when BSG_FIFO_SMALL_CLEAR_EN is defined.
module bsg_fifo_1r1w_small_count
  import bsg_fifo_small_pkg::*;
#(
  parameter int unsigned width_p            = 8,
  parameter int unsigned els_p              = 4,
  parameter int unsigned ready_THEN_valid_p = 0,
  parameter int unsigned afull_slack_p      = 1,
  parameter int unsigned aempty_slack_p     = 1,
  localparam int unsigned cnt_w_lp          = count_width(els_p)
) (
  input  logic                clk_i,
  input  logic                reset_i,
`ifdef BSG_FIFO_SMALL_CLEAR_EN
  input  logic                clear_i,
`endif
  input  logic                v_i,
  output logic                ready_o,
  input  logic [width_p-1:0]  data_i,
  output logic                v_o,
  output logic [width_p-1:0]  data_o,
  input  logic                yumi_i,
  output logic [cnt_w_lp-1:0] count_o,
  output logic                almost_full_o,
  output logic                almost_empty_o
);

  localparam int unsigned ptr_w_lp = ptr_width(els_p);
  localparam hs_mode_e    mode_lp  = (ready_THEN_valid_p != 0) ? HS_READY_THEN_VALID
                                                                : HS_READY_AND_VALID;

  // Elaboration-time parameter sanity.
  if (width_p < 1)              begin : g_bad_width  $error("width_p must be >= 1");         end
  if (els_p < 2)                begin : g_bad_els    $error("els_p must be >= 2");           end
  if (afull_slack_p >= els_p)   begin : g_bad_afull  $error("afull_slack_p must be < els_p"); end
  if (aempty_slack_p >= els_p)  begin : g_bad_aempty $error("aempty_slack_p must be < els_p"); end

  logic                clear;
  logic                enq;
  logic                deq;
  logic                full;
  logic                empty;
  logic [ptr_w_lp-1:0] rptr;
  logic [ptr_w_lp-1:0] wptr;
  logic [width_p-1:0]  mem [els_p];

`ifdef BSG_FIFO_SMALL_CLEAR_EN
  assign clear = clear_i;
`else
  assign clear = 1'b0;
`endif

  assign enq = v_i & ((mode_lp == HS_READY_THEN_VALID) ? 1'b1 : ready_o);
  assign deq = yumi_i;

  bsg_fifo_small_tracker #(
    .els_p          (els_p),
    .afull_slack_p  (afull_slack_p),
    .aempty_slack_p (aempty_slack_p)
  ) tracker (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .clear_i        (clear),
    .enq_i          (enq),
    .deq_i          (deq),
    .rptr_o         (rptr),
    .wptr_o         (wptr),
    .count_o        (count_o),
    .full_o         (full),
    .empty_o        (empty),
    .almost_full_o  (almost_full_o),
    .almost_empty_o (almost_empty_o)
  );

  // Storage write; contents are don't-care until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (enq) mem[wptr] <= data_i;
  end

  // Ready is held low while reset is asserted; no bypass from data_i to data_o.
  assign ready_o = ~full & ~reset_i;
  assign v_o     = ~empty;
  assign data_o  = mem[rptr];

`ifndef SYNTHESIS
  // Protocol checks on the consumer and ready-then-valid producer.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(yumi_i && !v_o)) else $error("yumi_i asserted while v_o is low");
      if (mode_lp == HS_READY_THEN_VALID)
        assert (!(v_i && !ready_o)) else $error("v_i asserted while ready_o is low");
    end
  end
`endif

endmodule

// File: tb/tb_bsg_fifo_1r1w_small_count.sv
// Bench for bsg_fifo_1r1w_small_count: directed vectors plus randomized traffic
// against a queue model, on a 4-deep and a 3-deep instance.
module tb_bsg_fifo_1r1w_small_count;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 4-deep instance
  logic       va = 1'b0, ya = 1'b0, ready_a, vo_a, af_a, ae_a;
  logic [7:0] da = 8'h00, dout_a;
  logic [2:0] cnt_a;
  // 3-deep instance
  logic       vb = 1'b0, yb = 1'b0, ready_b, vo_b, af_b, ae_b;
  logic [7:0] db = 8'h00, dout_b;
  logic [1:0] cnt_b;
`ifdef BSG_FIFO_SMALL_CLEAR_EN
  logic       clr_a = 1'b0, clr_b = 1'b0;
`endif

  bsg_fifo_1r1w_small_count #(.width_p(8), .els_p(4)) dut_a (
    .clk_i(clk), .reset_i(rst),
`ifdef BSG_FIFO_SMALL_CLEAR_EN
    .clear_i(clr_a),
`endif
    .v_i(va), .ready_o(ready_a), .data_i(da), .v_o(vo_a), .data_o(dout_a),
    .yumi_i(ya), .count_o(cnt_a), .almost_full_o(af_a), .almost_empty_o(ae_a));

  bsg_fifo_1r1w_small_count #(.width_p(8), .els_p(3)) dut_b (
    .clk_i(clk), .reset_i(rst),
`ifdef BSG_FIFO_SMALL_CLEAR_EN
    .clear_i(clr_b),
`endif
    .v_i(vb), .ready_o(ready_b), .data_i(db), .v_o(vo_b), .data_o(dout_b),
    .yumi_i(yb), .count_o(cnt_b), .almost_full_o(af_b), .almost_empty_o(ae_b));

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] qa[$];
  logic [7:0] qb[$];

  typedef struct {
    logic       v;
    logic       y;
    logic [7:0] d;
    int         cnt;
    logic       vo;
    logic       rdy;
    logic [7:0] dat;
    logic       af;
    logic       ae;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t mk(input logic v, input logic y, input logic [7:0] d, input int cnt,
                              input logic vo, input logic rdy, input logic [7:0] dat,
                              input logic af, input logic ae);
    vec_t r;
    r.v = v; r.y = y; r.d = d; r.cnt = cnt; r.vo = vo; r.rdy = rdy; r.dat = dat;
    r.af = af; r.ae = ae;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare one instance against its queue model.
  task automatic check_model(input int sel);
    int sz, els;
    els = (sel == 0) ? 4 : 3;
    sz  = (sel == 0) ? qa.size() : qb.size();
    if (sel == 0) begin
      chk("a.count", int'(cnt_a), sz);
      chk("a.v_o", int'(vo_a), int'(sz > 0));
      chk("a.ready_o", int'(ready_a), int'(sz < els));
      chk("a.almost_full", int'(af_a), int'((els - sz) <= 1));
      chk("a.almost_empty", int'(ae_a), int'(sz <= 1));
      if (sz > 0) chk("a.data_o", int'(dout_a), int'(qa[0]));
    end else begin
      chk("b.count", int'(cnt_b), sz);
      chk("b.v_o", int'(vo_b), int'(sz > 0));
      chk("b.ready_o", int'(ready_b), int'(sz < els));
      chk("b.almost_full", int'(af_b), int'((els - sz) <= 1));
      chk("b.almost_empty", int'(ae_b), int'(sz <= 1));
      if (sz > 0) chk("b.data_o", int'(dout_b), int'(qb[0]));
    end
  endtask

  // One clock with the given stimulus on one instance; model updated, outputs checked after.
  task automatic cyc(input int sel, input logic v, input logic y, input logic [7:0] d,
                     input logic clr);
    int sz, els;
    logic enq, deq;
    els = (sel == 0) ? 4 : 3;
    sz  = (sel == 0) ? qa.size() : qb.size();
    enq = v && (sz < els);
    deq = y && (sz > 0);
    if (sel == 0) begin va = v; ya = y; da = d; end
    else          begin vb = v; yb = y; db = d; end
`ifdef BSG_FIFO_SMALL_CLEAR_EN
    if (sel == 0) clr_a = clr; else clr_b = clr;
`endif
    if (sel == 0) begin
      if (clr) qa.delete();
      else begin
        if (deq) void'(qa.pop_front());
        if (enq) qa.push_back(d);
      end
    end else begin
      if (clr) qb.delete();
      else begin
        if (deq) void'(qb.pop_front());
        if (enq) qb.push_back(d);
      end
    end
    @(posedge clk);
    #1;
    va = 1'b0; ya = 1'b0; vb = 1'b0; yb = 1'b0;
`ifdef BSG_FIFO_SMALL_CLEAR_EN
    clr_a = 1'b0; clr_b = 1'b0;
`endif
    check_model(sel);
  endtask

  initial begin
    logic [7:0] rd;
    int         sel;

    // Fill/drain, then the full-edge deq-only case with a refill of 0xB5.
    tbl[0]  = mk(1, 0, 8'hA1, 1, 1, 1, 8'hA1, 0, 1);
    tbl[1]  = mk(1, 0, 8'hA2, 2, 1, 1, 8'hA1, 0, 0);
    tbl[2]  = mk(1, 0, 8'hA3, 3, 1, 1, 8'hA1, 1, 0);
    tbl[3]  = mk(1, 0, 8'hA4, 4, 1, 0, 8'hA1, 1, 0);
    tbl[4]  = mk(0, 1, 8'h00, 3, 1, 1, 8'hA2, 1, 0);
    tbl[5]  = mk(0, 1, 8'h00, 2, 1, 1, 8'hA3, 0, 0);
    tbl[6]  = mk(0, 1, 8'h00, 1, 1, 1, 8'hA4, 0, 1);
    tbl[7]  = mk(0, 1, 8'h00, 0, 0, 1, 8'h00, 0, 1);
    tbl[8]  = mk(1, 0, 8'hA1, 1, 1, 1, 8'hA1, 0, 1);
    tbl[9]  = mk(1, 0, 8'hA2, 2, 1, 1, 8'hA1, 0, 0);
    tbl[10] = mk(1, 0, 8'hA3, 3, 1, 1, 8'hA1, 1, 0);
    tbl[11] = mk(1, 0, 8'hA4, 4, 1, 0, 8'hA1, 1, 0);
    tbl[12] = mk(0, 1, 8'h00, 3, 1, 1, 8'hA2, 1, 0);
    tbl[13] = mk(1, 0, 8'hB5, 4, 1, 0, 8'hA2, 1, 0);
    tbl[14] = mk(0, 1, 8'h00, 3, 1, 1, 8'hA3, 1, 0);
    tbl[15] = mk(0, 1, 8'h00, 2, 1, 1, 8'hA4, 0, 0);
    tbl[16] = mk(0, 1, 8'h00, 1, 1, 1, 8'hB5, 0, 1);
    tbl[17] = mk(0, 1, 8'h00, 0, 0, 1, 8'h00, 0, 1);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset.v_o", int'(vo_a), 0);
    chk("reset.ready_o", int'(ready_a), 0);
    chk("reset.count", int'(cnt_a), 0);
    chk("reset.almost_empty", int'(ae_a), 1);
    chk("reset.almost_full", int'(af_a), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("release.ready_o", int'(ready_a), 1);
    chk("release.ready_o_b", int'(ready_b), 1);

    // Directed vector table on the 4-deep instance
    for (int i = 0; i < 18; i++) begin
      cyc(0, tbl[i].v, tbl[i].y, tbl[i].d, 1'b0);
      chk($sformatf("tbl%0d.count", i), int'(cnt_a), tbl[i].cnt);
      chk($sformatf("tbl%0d.v_o", i), int'(vo_a), int'(tbl[i].vo));
      chk($sformatf("tbl%0d.ready_o", i), int'(ready_a), int'(tbl[i].rdy));
      chk($sformatf("tbl%0d.afull", i), int'(af_a), int'(tbl[i].af));
      chk($sformatf("tbl%0d.aempty", i), int'(ae_a), int'(tbl[i].ae));
      if (tbl[i].vo) chk($sformatf("tbl%0d.data_o", i), int'(dout_a), int'(tbl[i].dat));
    end

    // Concurrent enq+deq at count 2 across several pointer wraps
    cyc(0, 1, 0, 8'hC0, 1'b0);
    cyc(0, 1, 0, 8'hC1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1, 1, 8'hC2 + 8'(i), 1'b0);
      chk("concurrent.count", int'(cnt_a), 2);
      chk("concurrent.head", int'(dout_a), int'(8'hC1 + 8'(i)));
    end

    // Reset mid-operation, asserted between edges
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midreset.v_o", int'(vo_a), 0);
    chk("midreset.ready_o", int'(ready_a), 0);
    chk("midreset.count", int'(cnt_a), 0);
    qa.delete();
    qb.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midreset.release_ready", int'(ready_a), 1);
    check_model(0);

    // Non-pow2 depth: single-entry rounds walk both pointers through 2->0
    for (int r = 0; r < 7; r++) begin
      cyc(1, 1, 0, 8'hD0 + 8'(r), 1'b0);
      chk("np2.head", int'(dout_b), int'(8'hD0 + 8'(r)));
      cyc(1, 0, 1, 8'h00, 1'b0);
    end
    // Non-pow2 depth: fill to full, then concurrent traffic
    cyc(1, 1, 0, 8'hE0, 1'b0);
    cyc(1, 1, 0, 8'hE1, 1'b0);
    cyc(1, 1, 0, 8'hE2, 1'b0);
    chk("np2.full_ready", int'(ready_b), 0);
    cyc(1, 1, 0, 8'hEE, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, 8'h00, 1'b0);

`ifdef BSG_FIFO_SMALL_CLEAR_EN
    // Clear with same-cycle enqueue drops everything
    cyc(0, 1, 0, 8'h31, 1'b0);
    cyc(0, 1, 0, 8'h32, 1'b0);
    cyc(0, 1, 0, 8'h33, 1'b0);
    cyc(0, 1, 0, 8'h34, 1'b1);
    chk("clear.count", int'(cnt_a), 0);
    chk("clear.v_o", int'(vo_a), 0);
    chk("clear.ready_o", int'(ready_a), 1);
    cyc(0, 1, 0, 8'h35, 1'b0);
    chk("clear.next_head", int'(dout_a), int'(8'h35));
    cyc(0, 0, 1, 8'h00, 1'b0);
`endif

    // Randomized legal traffic on both instances
    for (int i = 0; i < 600; i++) begin
      sel = int'($urandom_range(1, 0));
      rd  = 8'($urandom);
      if (sel == 0)
        cyc(0, 1'($urandom), (qa.size() > 0) ? 1'($urandom) : 1'b0, rd, 1'b0);
      else
        cyc(1, 1'($urandom), (qb.size() > 0) ? 1'($urandom) : 1'b0, rd, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
